micro_timer_sequencer: RTL and testbench

Parametrised microcoded controller for LED/lamp sequencing on iCEBlink40-class designs. Built-in sequencer with jump, conditional branch on latched external requests, call/return stack, and a prescaled delay timer. An external combinational ROM supplies microwords. Successor to the fixed 4-LED, 16-word timed sequencer; adds request inputs, subroutines, error reporting and width/depth parameters.

---
 rtl/micro_timer_sequencer_if.sv | 12 +
 rtl/micro_timer_sequencer.sv | 155 +++++++++++++++
 tb/tb_micro_timer_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/micro_timer_sequencer_if.sv
// Microword fetch bus between the sequencer and its external program ROM.
// No valid/ready: the ROM is combinational, so rom_data must reflect rom_addr within the same cycle.
interface micro_timer_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int WORD_W = 18
);
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/micro_timer_sequencer.sv
// Microcoded LED/lamp sequencer: jump, branch on latched requests, call/return stack
// and a prescaled delay timer driven from an external combinational ROM.
module micro_timer_sequencer #(
  parameter int OUT_W       = 4,
  parameter int ADDR_W      = 4,
  parameter int CONST_W     = 8,
  parameter int PRESCALE    = 19,
  parameter int IN_W        = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  micro_timer_sequencer_if.master rom,
  input  logic [IN_W-1:0]         req,
  output logic [OUT_W-1:0]        out,
  output logic [IN_W-1:0]         pending,
  output logic                    waiting,
  output logic                    err
);
  localparam int WORD_W = OUT_W + 6 + CONST_W;
  localparam int CNT_W  = CONST_W + PRESCALE;
  localparam int SP_W   = $clog2(STACK_DEPTH + 1);

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0, OP_JUMP = 3'd1, OP_WAIT = 3'd2, OP_BRIN = 3'd3,
    OP_CALL = 3'd4, OP_RET  = 3'd5, OP_HALT = 3'd6, OP_RSVD = 3'd7
  } op_t;

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc, target, stack_top;
  logic [CNT_W-1:0]  cnt, cnt_n, wait_val;
  logic [SP_W-1:0]   sp, sp_n;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic              push, err_set;
  logic [IN_W-1:0]   sync1, sync2, sync3, rise, clr;

  logic [OUT_W-1:0]   w_out;
  op_t                w_op;
  logic [2:0]         w_cond;
  logic [CONST_W-1:0] w_arg;

  assign w_out  = rom.rom_data[WORD_W-1 -: OUT_W];
  assign w_op   = op_t'(rom.rom_data[CONST_W+5 -: 3]);
  assign w_cond = rom.rom_data[CONST_W+2 -: 3];
  assign w_arg  = rom.rom_data[CONST_W-1:0];

  assign target   = w_arg[ADDR_W-1:0];
  assign pc_inc   = pc + ADDR_W'(1);
  assign wait_val = CNT_W'(w_arg) << PRESCALE;
  assign rise     = sync2 & ~sync3;

  assign rom.rom_addr = pc;
  assign waiting      = (state == ST_WAIT);

  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (sp == SP_W'(i + 1)) stack_top = stack[i];
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    sp_n    = sp;
    push    = 1'b0;
    err_set = 1'b0;
    clr     = '0;
    case (state)
      ST_WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = ST_RUN;
          pc_n    = pc_inc;
        end
      end
      default: begin
        case (w_op)
          OP_JUMP: pc_n = target;
          OP_WAIT: begin
            if (wait_val == '0) begin
              pc_n = pc_inc;
            end else begin
              cnt_n   = wait_val;
              state_n = ST_WAIT;
            end
          end
          OP_BRIN: begin
            pc_n = pc_inc;
            // cond values at or above IN_W never match, so they fall through
            for (int i = 0; i < IN_W; i++) begin
              if (w_cond == 3'(i) && pending[i]) begin
                pc_n   = target;
                clr[i] = 1'b1;
              end
            end
          end
          OP_CALL: begin
            if (sp < SP_W'(STACK_DEPTH)) begin
              push = 1'b1;
              sp_n = sp + SP_W'(1);
              pc_n = target;
            end else begin
              err_set = 1'b1;
              pc_n    = pc_inc;
            end
          end
          OP_RET: begin
            if (sp != '0) begin
              pc_n = stack_top;
              sp_n = sp - SP_W'(1);
            end else begin
              err_set = 1'b1;
              pc_n    = '0;
            end
          end
          OP_HALT: pc_n = pc;
          default: pc_n = pc_inc;
        endcase
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_RUN;
      pc      <= '0;
      cnt     <= '0;
      sp      <= '0;
      out     <= '0;
      err     <= 1'b0;
      pending <= '0;
      sync1   <= '0;
      sync2   <= '0;
      sync3   <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      cnt     <= cnt_n;
      sp      <= sp_n;
      out     <= w_out;
      err     <= err | err_set;
      sync1   <= req;
      sync2   <= sync1;
      sync3   <= sync2;
      // a fresh request edge outranks the branch consuming the same flag
      pending <= (pending & ~clr) | rise;
      for (int i = 0; i < STACK_DEPTH; i++)
        if (push && sp == SP_W'(i)) stack[i] <= pc_inc;
    end
  end
endmodule

// File: tb/tb_micro_timer_sequencer.sv
// Directed bench for micro_timer_sequencer with a small ROM array held in the bench.
module tb_micro_timer_sequencer;
  localparam int OUT_W = 4, ADDR_W = 4, CONST_W = 8, PRESCALE = 2, IN_W = 4, STACK_DEPTH = 2;
  localparam int WORD_W = OUT_W + 6 + CONST_W;

  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, WAITOP = 3'd2, BRIN = 3'd3;
  localparam logic [2:0] CALL = 3'd4, RET = 3'd5, HALT = 3'd6;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [IN_W-1:0]   req = '0;
  logic [OUT_W-1:0]  out;
  logic [IN_W-1:0]   pending;
  logic              waiting;
  logic              err;
  logic [WORD_W-1:0] rom [1 << ADDR_W];

  int vec_cnt  = 0;
  int miss_cnt = 0;

  micro_timer_sequencer_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();
  assign bus.rom_data = rom[bus.rom_addr];

  micro_timer_sequencer #(
    .OUT_W(OUT_W), .ADDR_W(ADDR_W), .CONST_W(CONST_W), .PRESCALE(PRESCALE),
    .IN_W(IN_W), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .rom(bus), .req(req),
    .out(out), .pending(pending), .waiting(waiting), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [WORD_W-1:0] mw(input logic [3:0] o, input logic [2:0] op,
                                           input logic [2:0] c, input logic [7:0] a);
    return {o, op, c, a};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic hold_reset();
    reset_n = 1'b0;
    req     = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = '0;
    tick();
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    hold_reset();
    rom[0] = mw(4'hF, HALT, 3'd0, 8'd0);
    tick();
    vec_cnt++; if (bus.rom_addr !== 4'd0) begin miss_cnt++; $display("FAIL reset_pc: got %0d expected 0", bus.rom_addr); end
    vec_cnt++; if (out !== 4'd0) begin miss_cnt++; $display("FAIL reset_out: got %0h expected 0", out); end
    vec_cnt++; if (waiting !== 1'b0) begin miss_cnt++; $display("FAIL reset_waiting: got %0b expected 0", waiting); end
    vec_cnt++; if (pending !== 4'd0) begin miss_cnt++; $display("FAIL reset_pending: got %0h expected 0", pending); end
    vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL reset_err: got %0b expected 0", err); end
  endtask

  task automatic test_alternate();
    logic [3:0] exp_out, exp_addr;
    hold_reset();
    rom[0] = mw(4'b1000, NEXT, 3'd0, 8'd0);
    rom[1] = mw(4'b0100, JUMP, 3'd0, 8'd0);
    release_reset();
    for (int n = 1; n <= 6; n++) begin
      tick();
      exp_out  = (n % 2 == 1) ? 4'b1000 : 4'b0100;
      exp_addr = (n % 2 == 1) ? 4'd1 : 4'd0;
      vec_cnt++; if (out !== exp_out) begin miss_cnt++; $display("FAIL alt_out[%0d]: got %b expected %b", n, out, exp_out); end
      vec_cnt++; if (bus.rom_addr !== exp_addr) begin miss_cnt++; $display("FAIL alt_addr[%0d]: got %0d expected %0d", n, bus.rom_addr, exp_addr); end
    end
  endtask

  task automatic test_wait();
    int high_cnt;
    int leave_at;
    hold_reset();
    rom[0] = mw(4'b0001, WAITOP, 3'd0, 8'd3);
    rom[1] = mw(4'b0010, HALT, 3'd0, 8'd0);
    release_reset();
    high_cnt = 0;
    leave_at = 0;
    for (int n = 1; n <= 40 && leave_at == 0; n++) begin
      tick();
      if (waiting === 1'b1) high_cnt++;
      if (bus.rom_addr !== 4'd0) leave_at = n;
      if (n == 6) begin
        vec_cnt++; if (out !== 4'b0001) begin miss_cnt++; $display("FAIL wait_out_hold: got %b expected 0001", out); end
      end
    end
    vec_cnt++; if (high_cnt !== 12) begin miss_cnt++; $display("FAIL wait_high_cycles: got %0d expected 12", high_cnt); end
    vec_cnt++; if (leave_at !== 13) begin miss_cnt++; $display("FAIL wait_leave_cycle: got %0d expected 13", leave_at); end
    tick();
    vec_cnt++; if (out !== 4'b0010) begin miss_cnt++; $display("FAIL wait_after_out: got %b expected 0010", out); end

    hold_reset();
    rom[0] = mw(4'b0001, WAITOP, 3'd0, 8'd0);
    rom[1] = mw(4'b0010, HALT, 3'd0, 8'd0);
    release_reset();
    tick();
    vec_cnt++; if (bus.rom_addr !== 4'd1) begin miss_cnt++; $display("FAIL wait0_pc: got %0d expected 1", bus.rom_addr); end
    vec_cnt++; if (waiting !== 1'b0) begin miss_cnt++; $display("FAIL wait0_waiting: got %0b expected 0", waiting); end
  endtask

  task automatic test_branch();
    int hit;
    logic pend_seen;
    hold_reset();
    rom[0] = mw(4'd1, BRIN, 3'd2, 8'd5);
    rom[1] = mw(4'd2, JUMP, 3'd0, 8'd0);
    rom[5] = mw(4'd5, HALT, 3'd0, 8'd0);
    release_reset();
    pend_seen = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick();
      if (pending !== 4'd0 || bus.rom_addr > 4'd1) pend_seen = 1'b1;
    end
    vec_cnt++; if (pend_seen !== 1'b0) begin miss_cnt++; $display("FAIL brin_idle_loop: got stray activity %0b expected 0", pend_seen); end
    req = 4'b0100;
    tick();
    req = 4'b0000;
    hit = 0;
    for (int n = 2; n <= 10 && hit == 0; n++) begin
      tick();
      if (n == 3) begin
        vec_cnt++; if (pending !== 4'b0100) begin miss_cnt++; $display("FAIL brin_pending_set: got %b expected 0100", pending); end
      end
      if (bus.rom_addr === 4'd5) hit = n;
    end
    vec_cnt++; if (hit != 4 && hit != 5) begin miss_cnt++; $display("FAIL brin_latency: got %0d expected 4 or 5", hit); end
    vec_cnt++; if (pending !== 4'b0000) begin miss_cnt++; $display("FAIL brin_pending_clr: got %b expected 0000", pending); end
    tick();
    vec_cnt++; if (out !== 4'd5) begin miss_cnt++; $display("FAIL brin_target_out: got %0d expected 5", out); end
  endtask

  task automatic test_set_wins();
    hold_reset();
    rom[0] = mw(4'd0, WAITOP, 3'd0, 8'd3);
    rom[1] = mw(4'd1, BRIN, 3'd2, 8'd5);
    rom[2] = mw(4'd2, HALT, 3'd0, 8'd0);
    rom[5] = mw(4'd5, HALT, 3'd0, 8'd0);
    release_reset();
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (n == 1)  req = 4'b0100;
      if (n == 3)  req = 4'b0000;
      if (n == 11) req = 4'b0100;
      if (n == 13) begin
        vec_cnt++; if (bus.rom_addr !== 4'd1) begin miss_cnt++; $display("FAIL setwin_pre_pc: got %0d expected 1", bus.rom_addr); end
        vec_cnt++; if (pending !== 4'b0100) begin miss_cnt++; $display("FAIL setwin_pre_pend: got %b expected 0100", pending); end
      end
    end
    vec_cnt++; if (bus.rom_addr !== 4'd5) begin miss_cnt++; $display("FAIL setwin_pc: got %0d expected 5", bus.rom_addr); end
    vec_cnt++; if (pending !== 4'b0100) begin miss_cnt++; $display("FAIL setwin_pend: got %b expected 0100", pending); end
  endtask

  task automatic test_call_stack();
    logic [3:0] exp_pc [6];
    logic       exp_err [6];
    exp_pc  = '{4'd4, 4'd8, 4'd9, 4'd5, 4'd1, 4'd0};
    exp_err = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    hold_reset();
    rom[0] = mw(4'd1, CALL, 3'd0, 8'd4);
    rom[4] = mw(4'd2, CALL, 3'd0, 8'd8);
    rom[8] = mw(4'd3, CALL, 3'd0, 8'd12);
    rom[9] = mw(4'd4, RET, 3'd0, 8'd0);
    rom[5] = mw(4'd5, RET, 3'd0, 8'd0);
    rom[1] = mw(4'd6, RET, 3'd0, 8'd0);
    release_reset();
    for (int n = 0; n < 6; n++) begin
      tick();
      vec_cnt++; if (bus.rom_addr !== exp_pc[n]) begin miss_cnt++; $display("FAIL stack_pc[%0d]: got %0d expected %0d", n, bus.rom_addr, exp_pc[n]); end
      vec_cnt++; if (err !== exp_err[n]) begin miss_cnt++; $display("FAIL stack_err[%0d]: got %0b expected %0b", n, err, exp_err[n]); end
    end
  endtask

  task automatic test_reset_mid_wait();
    hold_reset();
    rom[0] = mw(4'd1, WAITOP, 3'd0, 8'd3);
    rom[1] = mw(4'd2, HALT, 3'd0, 8'd0);
    release_reset();
    req = 4'b0001;
    for (int n = 1; n <= 5; n++) tick();
    vec_cnt++; if (waiting !== 1'b1 || pending !== 4'b0001 || out !== 4'd1) begin
      miss_cnt++; $display("FAIL midwait_pre: got w=%0b p=%b o=%0d expected w=1 p=0001 o=1", waiting, pending, out);
    end
    req = 4'b0000;
    #2 reset_n = 1'b0;
    #1;
    vec_cnt++; if (bus.rom_addr !== 4'd0) begin miss_cnt++; $display("FAIL midwait_pc: got %0d expected 0", bus.rom_addr); end
    vec_cnt++; if (out !== 4'd0) begin miss_cnt++; $display("FAIL midwait_out: got %0d expected 0", out); end
    vec_cnt++; if (waiting !== 1'b0) begin miss_cnt++; $display("FAIL midwait_waiting: got %0b expected 0", waiting); end
    vec_cnt++; if (pending !== 4'd0) begin miss_cnt++; $display("FAIL midwait_pending: got %b expected 0000", pending); end
    tick();
    release_reset();
    tick();
    vec_cnt++; if (waiting !== 1'b1 || out !== 4'd1 || bus.rom_addr !== 4'd0) begin
      miss_cnt++; $display("FAIL midwait_restart: got w=%0b o=%0d pc=%0d expected w=1 o=1 pc=0", waiting, out, bus.rom_addr);
    end
  endtask

  task automatic test_wrap();
    hold_reset();
    rom[0]  = mw(4'd3, JUMP, 3'd0, 8'd15);
    rom[15] = mw(4'hF, NEXT, 3'd0, 8'd0);
    release_reset();
    tick();
    vec_cnt++; if (bus.rom_addr !== 4'd15) begin miss_cnt++; $display("FAIL wrap_at15: got %0d expected 15", bus.rom_addr); end
    tick();
    vec_cnt++; if (bus.rom_addr !== 4'd0 || out !== 4'hF) begin
      miss_cnt++; $display("FAIL wrap_next: got pc=%0d o=%0h expected pc=0 o=f", bus.rom_addr, out);
    end

    hold_reset();
    rom[0]  = mw(4'd3, JUMP, 3'd0, 8'd15);
    rom[15] = mw(4'hE, CALL, 3'd0, 8'd7);
    rom[7]  = mw(4'd7, RET, 3'd0, 8'd0);
    release_reset();
    tick();
    tick();
    vec_cnt++; if (bus.rom_addr !== 4'd7) begin miss_cnt++; $display("FAIL wrap_call_pc: got %0d expected 7", bus.rom_addr); end
    tick();
    vec_cnt++; if (bus.rom_addr !== 4'd0 || err !== 1'b0) begin
      miss_cnt++; $display("FAIL wrap_ret_pc: got pc=%0d err=%0b expected pc=0 err=0", bus.rom_addr, err);
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_wait();
    test_branch();
    test_set_wins();
    test_call_stack();
    test_reset_mid_wait();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
